// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
// Contents: opcode values, FSM state codes, ALUOp codes, PCSrc/RegDst codes,
// and opcode-class helpers used by both next-state logic and decode.
package ctrl_pkg;

  // Opcodes
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_XORI  = 6'b010011;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLT   = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // FSM states
  typedef enum logic [2:0] {
    S_IF  = 3'b000,
    S_ID  = 3'b001,
    S_ELS = 3'b010,
    S_MEM = 3'b011,
    S_WLD = 3'b100,
    S_EBR = 3'b101,
    S_EAL = 3'b110,
    S_WAL = 3'b111
  } state_e;

  // ALU function codes
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_SLL = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;

  // Next-PC select
  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_RS     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  // Destination-register select
  localparam logic [1:0] RD_R31 = 2'b00;
  localparam logic [1:0] RD_RT  = 2'b01;
  localparam logic [1:0] RD_RD  = 2'b10;

  // Instructions that go through EAL/WAL
  function automatic logic is_alu_op(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI,
      OP_ORI, OP_XORI, OP_SLL, OP_SLT: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  // ALU forms whose second operand and destination come from the immediate/rt
  function automatic logic is_imm_op(input logic [5:0] op);
    case (op)
      OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_br_op(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Purpose: combinational strobe/mux decode from (state, op, zero).
// Latency: zero cycles, purely combinational. Backpressure: none.
// Ports: state/op/zero in; PC/IR/memory/regfile strobes and mux selects out.
// Config: MULTICYCLE_CTRL_JAL_EN enables jal (link to $31) and jr in ID.
import ctrl_pkg::*;

module multicycle_ctrl_decode #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 4
) (
  input  logic [2:0]         state,
  input  logic [OP_W-1:0]    op,
  input  logic               zero,
  output logic               PCWre,
  output logic               IRWre,
  output logic               InsMemRW,
  output logic               RegWre,
  output logic               mRD,
  output logic               mWR,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic               ExtSel,
  output logic               DBDataSrc,
  output logic               WrRegDSrc,
  output logic [1:0]         PCSrc,
  output logic [1:0]         RegDst,
  output logic [ALUOP_W-1:0] ALUOp
);

  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    RegWre    = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    DBDataSrc = 1'b0;
    WrRegDSrc = 1'b0;
    PCSrc     = PC_SEQ;
    RegDst    = RD_R31;
    ALUOp     = ALU_ADD;

    case (state)
      S_IF: begin
        InsMemRW = 1'b1;
        IRWre    = 1'b1;
      end

      S_ID: begin
        case (op)
          OP_J: begin
            PCWre = 1'b1;
            PCSrc = PC_JUMP;
          end
          OP_HALT: ; // PC never advances, so halt is refetched forever
`ifdef MULTICYCLE_CTRL_JAL_EN
          OP_JAL: begin
            RegWre    = 1'b1;
            RegDst    = RD_R31;
            WrRegDSrc = 1'b0;     // write PC+4 as the link address
            PCWre     = 1'b1;
            PCSrc     = PC_JUMP;
          end
          OP_JR: begin
            PCWre = 1'b1;
            PCSrc = PC_RS;
          end
`endif
          default: begin
            // Anything that ends here (unknown opcodes) retires as a NOP;
            // instructions continuing to later states must not move the PC.
            if (!is_alu_op(op) && !is_mem_op(op) && !is_br_op(op)) begin
              PCWre = 1'b1;
              PCSrc = PC_SEQ;
            end
          end
        endcase
      end

      // ALU controls stay stable from execute through write-back so the
      // datapath result does not change while it is being written.
      S_EAL, S_WAL, S_ELS: begin
        ExtSel  = 1'b1;
        ALUSrcB = is_imm_op(op) || is_mem_op(op);
        case (op)
          OP_SUB:  ALUOp = ALU_SUB;
          OP_AND,
          OP_ANDI: ALUOp = ALU_AND;
          OP_ORI:  ALUOp = ALU_OR;
          OP_XORI: ALUOp = ALU_XOR;
          OP_SLT:  ALUOp = ALU_SLT;
          OP_SLL: begin
            ALUOp   = ALU_SLL;
            ALUSrcA = 1'b1;       // shift amount comes from shamt
          end
          default: ALUOp = ALU_ADD;
        endcase
        if (op == OP_ANDI || op == OP_ORI || op == OP_XORI) ExtSel = 1'b0;
        if (state == S_WAL) begin
          RegWre    = 1'b1;
          WrRegDSrc = 1'b1;
          DBDataSrc = 1'b0;
          RegDst    = is_imm_op(op) ? RD_RT : RD_RD;
          PCWre     = 1'b1;
        end
      end

      S_MEM: begin
        if (op == OP_LW) mRD = 1'b1;
        if (op == OP_SW) begin
          mWR   = 1'b1;
          PCWre = 1'b1;
        end
      end

      S_WLD: begin
        RegWre    = 1'b1;
        RegDst    = RD_RT;
        DBDataSrc = 1'b1;
        WrRegDSrc = 1'b1;
        PCWre     = 1'b1;
      end

      S_EBR: begin
        ALUOp = ALU_SUB;
        PCWre = 1'b1;
        if (((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero)) PCSrc = PC_BRANCH;
      end

      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose: multi-cycle MIPS control FSM (IF/ID/EAL/WAL/ELS/MEM/WLD/EBR).
// Latency: outputs combinational from registered state; 2-5 cycles per instruction.
// Backpressure: none; halt stalls by never raising PCWre.
// Ports: CLK, RST (async active-low), op, zero in; state and all datapath controls out.
// Config: MULTICYCLE_CTRL_JAL_EN enables jal/jr decode (see decode sub-module).
import ctrl_pkg::*;

module multicycle_ctrl #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [OP_W-1:0]    op,
  input  logic               zero,
  output logic [2:0]         state,
  output logic               PCWre,
  output logic               IRWre,
  output logic               InsMemRW,
  output logic               RegWre,
  output logic               mRD,
  output logic               mWR,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic               ExtSel,
  output logic               DBDataSrc,
  output logic               WrRegDSrc,
  output logic [1:0]         PCSrc,
  output logic [1:0]         RegDst,
  output logic [ALUOP_W-1:0] ALUOp
);

  state_e state_q, state_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_IF;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if      (is_alu_op(op)) state_d = S_EAL;
        else if (is_mem_op(op)) state_d = S_ELS;
        else if (is_br_op(op))  state_d = S_EBR;
        else                    state_d = S_IF;
      end
      S_EAL: state_d = S_WAL;
      S_ELS: state_d = S_MEM;
      S_MEM: state_d = (op == OP_LW) ? S_WLD : S_IF;
      default: state_d = S_IF; // WAL, WLD, EBR all retire
    endcase
  end

  assign state = state_q;

  multicycle_ctrl_decode #(
    .OP_W    (OP_W),
    .ALUOP_W (ALUOP_W)
  ) u_decode (
    .state     (state_q),
    .op        (op),
    .zero      (zero),
    .PCWre     (PCWre),
    .IRWre     (IRWre),
    .InsMemRW  (InsMemRW),
    .RegWre    (RegWre),
    .mRD       (mRD),
    .mWR       (mWR),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ExtSel    (ExtSel),
    .DBDataSrc (DBDataSrc),
    .WrRegDSrc (WrRegDSrc),
    .PCSrc     (PCSrc),
    .RegDst    (RegDst),
    .ALUOp     (ALUOp)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through
// its state sequence and checks strobes against hand-derived values.
module tb_multicycle_ctrl;

  logic       CLK, RST, zero;
  logic [5:0] op;
  logic [2:0] state;
  logic       PCWre, IRWre, InsMemRW, RegWre, mRD, mWR;
  logic       ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc;
  logic [1:0] PCSrc, RegDst;
  logic [3:0] ALUOp;

  int tests = 0;
  int fails = 0;

  multicycle_ctrl dut (
    .CLK(CLK), .RST(RST), .op(op), .zero(zero), .state(state),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .RegWre(RegWre),
    .mRD(mRD), .mWR(mWR), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ExtSel(ExtSel), .DBDataSrc(DBDataSrc), .WrRegDSrc(WrRegDSrc),
    .PCSrc(PCSrc), .RegDst(RegDst), .ALUOp(ALUOp)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST  = 1'b0;
    op   = 6'b000000;
    zero = 1'b0;
    #12;
    // Reset state: IF decode
    chk("rst_state",    {29'd0, state}, 32'd0);
    chk("rst_IRWre",    {31'd0, IRWre}, 32'd1);
    chk("rst_InsMemRW", {31'd0, InsMemRW}, 32'd1);
    chk("rst_PCWre",    {31'd0, PCWre}, 32'd0);
    chk("rst_RegWre",   {31'd0, RegWre}, 32'd0);
    chk("rst_mWR",      {31'd0, mWR}, 32'd0);
    chk("rst_PCSrc",    {30'd0, PCSrc}, 32'd0);
    chk("rst_ALUOp",    {28'd0, ALUOp}, 32'd0);
    RST = 1'b1;

    // add: IF ID EAL WAL IF
    op = 6'b000000;
    tick(); chk("add_ID",      {29'd0, state}, 32'd1);
            chk("add_ID_pcw",  {31'd0, PCWre}, 32'd0);
            chk("add_ID_irw",  {31'd0, IRWre}, 32'd0);
    tick(); chk("add_EAL",     {29'd0, state}, 32'd6);
            chk("add_EAL_rw",  {31'd0, RegWre}, 32'd0);
            chk("add_EAL_op",  {28'd0, ALUOp}, 32'd0);
            chk("add_EAL_ext", {31'd0, ExtSel}, 32'd1);
    tick(); chk("add_WAL",     {29'd0, state}, 32'd7);
            chk("add_WAL_rw",  {31'd0, RegWre}, 32'd1);
            chk("add_WAL_dst", {30'd0, RegDst}, 32'd2);
            chk("add_WAL_pcw", {31'd0, PCWre}, 32'd1);
            chk("add_WAL_wrs", {31'd0, WrRegDSrc}, 32'd1);
            chk("add_WAL_dbs", {31'd0, DBDataSrc}, 32'd0);
    tick(); chk("add_IF",      {29'd0, state}, 32'd0);

    // ori: OR, immediate B, zero-extend, rt destination
    op = 6'b010010;
    tick(); tick();
    chk("ori_EAL_op",  {28'd0, ALUOp}, 32'd3);
    chk("ori_EAL_srb", {31'd0, ALUSrcB}, 32'd1);
    chk("ori_EAL_ext", {31'd0, ExtSel}, 32'd0);
    tick();
    chk("ori_WAL_dst", {30'd0, RegDst}, 32'd1);
    chk("ori_WAL_op",  {28'd0, ALUOp}, 32'd3);
    tick();

    // sll: shamt on A, shift op
    op = 6'b011000;
    tick(); tick();
    chk("sll_EAL_op",  {28'd0, ALUOp}, 32'd2);
    chk("sll_EAL_sra", {31'd0, ALUSrcA}, 32'd1);
    chk("sll_EAL_srb", {31'd0, ALUSrcB}, 32'd0);
    tick(); tick();

    // slt: signed compare
    op = 6'b100111;
    tick(); tick();
    chk("slt_EAL_op",  {28'd0, ALUOp}, 32'd5);
    tick();
    chk("slt_WAL_dst", {30'd0, RegDst}, 32'd2);
    tick();

    // lw: IF ID ELS MEM WLD IF
    op = 6'b110001;
    tick(); chk("lw_ID_pcw",   {31'd0, PCWre}, 32'd0);
    tick(); chk("lw_ELS",      {29'd0, state}, 32'd2);
            chk("lw_ELS_srb",  {31'd0, ALUSrcB}, 32'd1);
            chk("lw_ELS_ext",  {31'd0, ExtSel}, 32'd1);
    tick(); chk("lw_MEM",      {29'd0, state}, 32'd3);
            chk("lw_MEM_rd",   {31'd0, mRD}, 32'd1);
            chk("lw_MEM_pcw",  {31'd0, PCWre}, 32'd0);
    tick(); chk("lw_WLD",      {29'd0, state}, 32'd4);
            chk("lw_WLD_dbs",  {31'd0, DBDataSrc}, 32'd1);
            chk("lw_WLD_rw",   {31'd0, RegWre}, 32'd1);
            chk("lw_WLD_dst",  {30'd0, RegDst}, 32'd1);
            chk("lw_WLD_pcw",  {31'd0, PCWre}, 32'd1);
    tick(); chk("lw_IF",       {29'd0, state}, 32'd0);

    // sw: IF ID ELS MEM IF
    op = 6'b110000;
    tick(); tick(); tick();
    chk("sw_MEM",     {29'd0, state}, 32'd3);
    chk("sw_MEM_wr",  {31'd0, mWR}, 32'd1);
    chk("sw_MEM_rd",  {31'd0, mRD}, 32'd0);
    chk("sw_MEM_pcw", {31'd0, PCWre}, 32'd1);
    tick(); chk("sw_IF", {29'd0, state}, 32'd0);

    // beq: zero is looked at combinationally in EBR
    op = 6'b110100;
    tick(); tick();
    chk("beq_EBR",    {29'd0, state}, 32'd5);
    chk("beq_ALUOp",  {28'd0, ALUOp}, 32'd1);
    chk("beq_pcw",    {31'd0, PCWre}, 32'd1);
    zero = 1'b1; #1; chk("beq_z1_src", {30'd0, PCSrc}, 32'd1);
    zero = 1'b0; #1; chk("beq_z0_src", {30'd0, PCSrc}, 32'd0);
    tick(); chk("beq_IF", {29'd0, state}, 32'd0);

    op = 6'b110101;
    tick(); tick();
    chk("bne_EBR",    {29'd0, state}, 32'd5);
    zero = 1'b0; #1; chk("bne_z0_src", {30'd0, PCSrc}, 32'd1);
    zero = 1'b1; #1; chk("bne_z1_src", {30'd0, PCSrc}, 32'd0);
    tick(); chk("bne_IF", {29'd0, state}, 32'd0);
    zero = 1'b0;

    // j: retires from ID
    op = 6'b111000;
    tick(); chk("j_ID_pcw", {31'd0, PCWre}, 32'd1);
            chk("j_ID_src", {30'd0, PCSrc}, 32'd3);
    tick(); chk("j_IF",     {29'd0, state}, 32'd0);

    // unlisted opcode: NOP
    op = 6'b101010;
    tick(); chk("nop_ID_pcw", {31'd0, PCWre}, 32'd1);
            chk("nop_ID_src", {30'd0, PCSrc}, 32'd0);
    tick(); chk("nop_IF",     {29'd0, state}, 32'd0);

    // jal / jr
    op = 6'b111010;
    tick();
`ifdef MULTICYCLE_CTRL_JAL_EN
    chk("jal_rw",  {31'd0, RegWre}, 32'd1);
    chk("jal_dst", {30'd0, RegDst}, 32'd0);
    chk("jal_src", {30'd0, PCSrc}, 32'd3);
    chk("jal_wrs", {31'd0, WrRegDSrc}, 32'd0);
`else
    chk("jal_rw",  {31'd0, RegWre}, 32'd0);
    chk("jal_src", {30'd0, PCSrc}, 32'd0);
`endif
    chk("jal_pcw", {31'd0, PCWre}, 32'd1);
    tick();
    op = 6'b111001;
    tick();
`ifdef MULTICYCLE_CTRL_JAL_EN
    chk("jr_src", {30'd0, PCSrc}, 32'd2);
`else
    chk("jr_src", {30'd0, PCSrc}, 32'd0);
`endif
    chk("jr_pcw", {31'd0, PCWre}, 32'd1);
    tick();

    // halt: PCWre never rises, state ping-pongs IF/ID
    op = 6'b111111;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("halt_state", {29'd0, state}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("halt_pcw",   {31'd0, PCWre}, 32'd0);
    end
    // 12 edges from IF leave us back in IF

    // async reset during EAL
    op = 6'b000000;
    tick(); tick();
    chk("arst_pre_EAL", {29'd0, state}, 32'd6);
    #2 RST = 1'b0; #1;
    chk("arst_EAL_state", {29'd0, state}, 32'd0);
    chk("arst_EAL_irw",   {31'd0, IRWre}, 32'd1);
    #2 RST = 1'b1;
    // async reset during WAL drops the pending register write
    tick(); tick(); tick();
    chk("arst_pre_WAL", {29'd0, state}, 32'd7);
    chk("arst_pre_rw",  {31'd0, RegWre}, 32'd1);
    #2 RST = 1'b0; #1;
    chk("arst_WAL_state", {29'd0, state}, 32'd0);
    chk("arst_WAL_rw",    {31'd0, RegWre}, 32'd0);
    chk("arst_WAL_pcw",   {31'd0, PCWre}, 32'd0);
    tick();
    chk("arst_hold_state", {29'd0, state}, 32'd0);
    RST = 1'b1;
    tick();
    chk("arst_rel_ID", {29'd0, state}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
